result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Consumes the wide result word produced by lab_top and streams it out as narrow beats over a valid/ready interface. It is the transmitter end of the result path.
- Sits between lab_top.result and the downstream byte sink (host link/UART bridge).
- Accepts one IN_W-bit word and emits IN_W/OUT_W beats, with first/last framing. Back-to-back words stream without bubbles.

Parameters:
- IN_W, 256, width of the input result word.
- OUT_W, 8, width of one output beat. IN_W must be an integer multiple of OUT_W (elaboration-time assertion).
- MSB_FIRST, 1, 1 = emit in_data[IN_W-1 -: OUT_W] first; 0 = emit in_data[OUT_W-1:0] first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  IN_W  result word from lab_top.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  OUT_W  current output beat.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the beat this cycle.
- out_first  output  1  current beat is beat 0 of a word.
- out_last  output  1  current beat is beat NBEATS-1 of a word.
- busy  output  1  a word is held (out_valid = 1).

Behaviour:
- NBEATS = IN_W/OUT_W (32 by default). CNT_W = $clog2(NBEATS).
- State: IDLE (no word held) and SHIFT (word held, emitting beats). busy = (state == SHIFT).
- Reset (rst_n = 0, async): state = IDLE, shift register = 0, beat_cnt = 0. Outputs: out_valid = 0, out_first = 0, out_last = 0, out_data = 0, in_ready = 1 once rst_n deasserts. Reset mid-word discards the held word with no partial flush.
- Handshake rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_data, out_first and out_last hold stable while out_valid & !out_ready.
  - out_valid never drops without a transfer, except on reset.
- in_ready = (state == IDLE) | (out_ready & out_last). This is combinational from out_ready, and is what allows back-to-back words.
- IDLE -> SHIFT: on an input transfer, load in_data into the shift register and set beat_cnt = 0. out_valid rises the next cycle, so latency from input transfer to first beat valid is 1 cycle.
- SHIFT, output transfer with beat_cnt < NBEATS-1: shift by OUT_W toward the output end and increment beat_cnt.
- SHIFT, output transfer with beat_cnt == NBEATS-1:
  - If an input transfer happens in the same cycle, reload and set beat_cnt = 0, staying in SHIFT with no bubble.
  - Otherwise go to SHIFT -> IDLE and set out_valid = 0 next cycle.
- out_data = shift-register MSB slice if MSB_FIRST, else LSB slice. out_first = (beat_cnt == 0). out_last = (beat_cnt == NBEATS-1). All three are gated by out_valid.
- in_valid while in SHIFT with beat_cnt < NBEATS-1: not accepted. in_ready = 0, and the source must hold the word.
- Throughput: NBEATS cycles per word under continuous out_ready.
- The shift register is loaded only on an input transfer. No data-path arithmetic; beat_cnt is an unsigned CNT_W counter and never wraps past NBEATS-1.

Decomposition:
- Shared package eda_pkg holds: RESULT_W = 256, BEAT_W = 8, NBEATS = RESULT_W/BEAT_W, and typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t.
- No sub-module needed; the shift register and counter live in one always_ff block.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles, then release -> out_valid = 0, busy = 0, in_ready = 1. Assert rst_n low asynchronously between edges -> outputs clear immediately.
- Single word 256'h0102...1F20 (byte k = k+1), out_ready = 1 -> out_valid rises 1 cycle after the input transfer. 32 beats are emitted as 0x01..0x20, out_first only on 0x01, out_last only on 0x20. in_ready = 0 on beats 0-30 and 1 on beat 31. busy deasserts after beat 31.
- Backpressure: toggle out_ready pseudo-randomly during one word -> out_data is stable whenever out_valid & !out_ready. The byte sequence is identical to the previous test, and no beat is lost or duplicated.
- Back-to-back: in_valid held high with words A then B, out_ready = 1 -> exactly 64 consecutive valid beats with no gap. out_last(A) is followed directly by out_first(B).
- MSB_FIRST = 0 with the same word -> beats emitted 0x20..0x01.
- Reset mid-word: deassert rst_n at beat 10, then release -> no further beats from the old word. The next input word starts with out_first and a full 32-beat count.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result transmit path: word/beat geometry and
// the serializer state encoding.
package eda_pkg;

    localparam int RESULT_W = 256;
    localparam int BEAT_W   = 8;
    localparam int NBEATS   = RESULT_W / BEAT_W;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage : eda_pkg

// File: rtl/result_serializer.sv
// Streams one wide result word out as IN_W/OUT_W narrow beats over a
// valid/ready link, with first/last framing and bubble-free back-to-back words.
module result_serializer
    import eda_pkg::*;
#(
    parameter int IN_W      = RESULT_W,
    parameter int OUT_W     = BEAT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic             busy
);

    localparam int NB    = IN_W / OUT_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

    generate
        if ((IN_W % OUT_W) != 0 || IN_W < OUT_W) begin : g_width_check
            $error("result_serializer: IN_W must be an integer multiple of OUT_W");
        end
    endgenerate

    ser_state_t       state_r, state_nxt_s;
    logic [IN_W-1:0]  shift_r, shift_nxt_s;
    logic [CNT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;

    logic out_valid_s, out_last_s, in_ready_s;
    logic in_xfer_s, out_xfer_s;

    assign out_valid_s = (state_r == SER_SHIFT);
    assign out_last_s  = out_valid_s & (beat_cnt_r == LAST_CNT);
    // Combinational from out_ready so a new word can load on the final beat.
    assign in_ready_s  = (state_r == SER_IDLE) | (out_ready & out_last_s);
    assign in_xfer_s   = in_valid & in_ready_s;
    assign out_xfer_s  = out_valid_s & out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign busy      = out_valid_s;
    assign out_last  = out_last_s;
    assign out_first = out_valid_s & (beat_cnt_r == {CNT_W{1'b0}});
    assign out_data  = out_valid_s
                     ? (MSB_FIRST ? shift_r[IN_W-1 -: OUT_W] : shift_r[OUT_W-1:0])
                     : {OUT_W{1'b0}};

    // Next-state, shift and beat-count decode
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            SER_IDLE: begin
                if (in_xfer_s) begin
                    state_nxt_s    = SER_SHIFT;
                    shift_nxt_s    = in_data;
                    beat_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = SER_IDLE;
                end
            end
            SER_SHIFT: begin
                if (out_xfer_s && (beat_cnt_r == LAST_CNT)) begin
                    if (in_xfer_s) begin
                        shift_nxt_s    = in_data;
                        beat_cnt_nxt_s = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s    = SER_IDLE;
                        beat_cnt_nxt_s = {CNT_W{1'b0}};
                    end
                end else if (out_xfer_s) begin
                    // Move the next beat into the output slice.
                    if (MSB_FIRST) begin
                        shift_nxt_s = shift_r << OUT_W;
                    end else begin
                        shift_nxt_s = shift_r >> OUT_W;
                    end
                    beat_cnt_nxt_s = beat_cnt_r + CNT_W'(1);
                end else begin
                    state_nxt_s = SER_SHIFT;
                end
            end
            default: begin
                state_nxt_s    = SER_IDLE;
                shift_nxt_s    = {IN_W{1'b0}};
                beat_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shift register and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SER_IDLE;
            shift_r    <= {IN_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

endmodule : result_serializer

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: MSB-first and LSB-first instances
// share one stimulus stream; each task checks one behaviour.
module tb_result_serializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] in_data;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready, out_valid, out_first, out_last, busy;
    logic [7:0]   out_data;
    logic         l_in_ready, l_out_valid, l_out_first, l_out_last, l_busy;
    logic [7:0]   l_out_data;

    int checks = 0;
    int fails  = 0;

    logic [255:0] word_a, word_b;

    always #5 clk = ~clk;

    result_serializer #(.IN_W(256), .OUT_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    result_serializer #(.IN_W(256), .OUT_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_first(l_out_first), .out_last(l_out_last),
        .busy(l_busy)
    );

    // Byte k counted from the MSB end equals base + k.
    function automatic logic [255:0] mk_word(input logic [7:0] base);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) w[255-8*k -: 8] = base + 8'(k);
        return w;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL reset_framing: got %0b%0b want 00", out_first, out_last); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_idle: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_single;
        logic [7:0] exp;
        in_data = word_a; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_accept: in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_latency: out_valid got %0b want 1", out_valid); end
        for (int k = 0; k < 32; k++) begin
            exp = 8'(k + 1);
            checks++; if (out_data !== exp) begin fails++; $display("FAIL single_data[%0d]: got %h want %h", k, out_data, exp); end
            checks++; if (out_first !== (k == 0) || out_last !== (k == 31)) begin fails++; $display("FAIL single_framing[%0d]: got first=%0b last=%0b", k, out_first, out_last); end
            checks++; if (in_ready !== (k == 31)) begin fails++; $display("FAIL single_in_ready[%0d]: got %0b want %0b", k, in_ready, (k == 31)); end
            checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy[%0d]: got %0b want 1", k, busy); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
    endtask

    task automatic test_lsb_first;
        logic [7:0] exp;
        in_data = word_a; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp = 8'(32 - k);
            checks++; if (l_out_valid !== 1'b1 || l_out_data !== exp) begin fails++; $display("FAIL lsb_data[%0d]: got v=%0b %h want %h", k, l_out_valid, l_out_data, exp); end
            checks++; if (l_out_first !== (k == 0) || l_out_last !== (k == 31)) begin fails++; $display("FAIL lsb_framing[%0d]: got first=%0b last=%0b", k, l_out_first, l_out_last); end
            @(negedge clk);
        end
        checks++; if (l_out_valid !== 1'b0) begin fails++; $display("FAIL lsb_done: out_valid got %0b want 0", l_out_valid); end
    endtask

    task automatic test_backpressure;
        logic [7:0] lfsr = 8'hA5;
        int idx = 0;
        int cyc = 0;
        in_data = word_a; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        while (idx < 32 && cyc < 400) begin
            out_ready = lfsr[0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(idx + 1)) begin fails++; $display("FAIL bp_data[%0d]: got v=%0b %h want %h", idx, out_valid, out_data, 8'(idx + 1)); end
            checks++; if (out_first !== (idx == 0) || out_last !== (idx == 31)) begin fails++; $display("FAIL bp_framing[%0d]: got first=%0b last=%0b", idx, out_first, out_last); end
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        checks++; if (idx != 32) begin fails++; $display("FAIL bp_timeout: beats got %0d want 32", idx); end
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_done: out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        in_data = word_a; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = word_b;
        for (int k = 0; k < 64; k++) begin
            if (k == 32) in_valid = 1'b0;
            exp = (k < 32) ? 8'(k + 1) : 8'(8'h80 + 8'(k - 32));
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL b2b_data[%0d]: got v=%0b %h want %h", k, out_valid, out_data, exp); end
            checks++; if (out_first !== (k == 0 || k == 32) || out_last !== (k == 31 || k == 63)) begin fails++; $display("FAIL b2b_framing[%0d]: got first=%0b last=%0b", k, out_first, out_last); end
            if (k == 31) begin
                checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
            end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_done: out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] exp;
        in_data = word_a; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (out_data !== 8'd11) begin fails++; $display("FAIL mid_pre_reset: got %h want 0b", out_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_async_clear: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
        checks++; if (out_data !== 8'h00 || out_first !== 1'b0 || out_last !== 1'b0) begin fails++; $display("FAIL mid_async_outputs: got %h %0b%0b want 00 00", out_data, out_first, out_last); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_after_release: got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
        in_data = word_b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp = 8'(8'h80 + 8'(k));
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL mid_new_data[%0d]: got v=%0b %h want %h", k, out_valid, out_data, exp); end
            checks++; if (out_first !== (k == 0) || out_last !== (k == 31)) begin fails++; $display("FAIL mid_new_framing[%0d]: got first=%0b last=%0b", k, out_first, out_last); end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_done: out_valid got %0b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_a = mk_word(8'h01);
        word_b = mk_word(8'h80);
        test_reset();
        test_single();
        test_lsb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_result_serializer
